scan_chain_driver: RTL and testbench

//  Tester-side end of the scan interface (SE / scan_in / scan_out) on our scannable blocks such as the 4-bit counter.

---
 rtl/scan_chain_driver_pkg.sv | 23 ++
 rtl/scan_chain_driver_if.sv | 45 ++++
 rtl/scan_chain_driver_phase_counter.sv | 39 +++
 rtl/scan_chain_driver.sv | 188 ++++++++++++++++++
 tb/tb_scan_chain_driver.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/scan_chain_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_drv_pkg
// Description : Shared definitions for the scan chain driver: FSM state
//               encodings and the default chain length.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_drv_pkg;

    // Default number of flops in the target chain (4-bit scan counter).
    localparam int DEFAULT_CHAIN_LEN = 4;

    // Run sequence: IDLE -> LOAD -> CAPTURE -> UNLOAD -> DONE -> IDLE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage : scan_drv_pkg
`default_nettype wire

// File: rtl/scan_chain_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : scan_chain_driver_if
// Description : Bundle of sequencer-side and chain-side signals of the scan
//               chain driver.
//   start       sequencer -> driver  request a load/capture/unload run
//   pattern     sequencer -> driver  load vector (bit k ends in flop k)
//   expect_val  sequencer -> driver  expected chain contents after capture
//   expect_mask sequencer -> driver  1 = compare bit, 0 = don't care
//   scan_out    chain     -> driver  last flop of the chain
//   SE          driver    -> chain   scan enable
//   scan_in     driver    -> chain   serial data into flop 0
//   busy/done/pass/response driver -> sequencer  run status and result
//   Modport slave is the driver side, master the sequencer/chain side.
// Revision    : 1.0 - initial release
// ============================================================================
interface scan_chain_driver_if
    import scan_drv_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pattern;
    logic [CHAIN_LEN-1:0] expect_val;
    logic [CHAIN_LEN-1:0] expect_mask;
    logic                 scan_out;
    logic                 SE;
    logic                 scan_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CHAIN_LEN-1:0] response;

    modport slave (
        input  start, pattern, expect_val, expect_mask, scan_out,
        output SE, scan_in, busy, done, pass, response
    );

    modport master (
        output start, pattern, expect_val, expect_mask, scan_out,
        input  SE, scan_in, busy, done, pass, response
    );

endinterface : scan_chain_driver_if
`default_nettype wire

// File: rtl/scan_chain_driver_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : scan_phase_counter
// Description : Loadable down-counter with zero flag. Times the LOAD, CAPTURE
//               and UNLOAD phases of the scan chain driver. Saturates at 0.
//   clk, reset  clock and synchronous active-high reset
//   load        load load_val (has priority over dec)
//   load_val    terminal count for the phase being entered
//   dec         decrement by one unless already zero
//   zero        count is zero (last cycle of the phase)
// Revision    : 1.0 - initial release
// ============================================================================
module scan_phase_counter #(
    parameter int CNT_W = 3
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    input  wire logic             dec,
    output logic                  zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule : scan_phase_counter
`default_nettype wire

// File: rtl/scan_chain_driver.sv
`default_nettype none
// ============================================================================
// Module      : scan_chain_driver
// Description : Tester-side end of a scan chain. Shifts a pattern in MSB
//               first, drops SE for CAPTURE_CYCLES functional clocks, shifts
//               the chain back out and compares it against a masked
//               expected vector.
//   clk    rising-edge clock, shared with the chain under test
//   reset  synchronous active-high reset; aborts a run without done
//   bus    scan_chain_driver_if.slave (sequencer handshake + scan pins)
// Revision    : 1.0 - initial release
// ============================================================================
module scan_chain_driver
    import scan_drv_pkg::*;
#(
    parameter int CHAIN_LEN      = DEFAULT_CHAIN_LEN,
    parameter int CAPTURE_CYCLES = 1,
    parameter int CNT_W          = $clog2(CHAIN_LEN + CAPTURE_CYCLES + 1)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    scan_chain_driver_if.slave bus
);

    // Phase counters load "length - 1" so the phase ends on the zero cycle.
    localparam logic [CNT_W-1:0] c_len_m1      = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] c_cap_m1      =
        CNT_W'((CAPTURE_CYCLES > 0) ? (CAPTURE_CYCLES - 1) : 0);
    localparam bit               c_has_capture = (CAPTURE_CYCLES > 0);

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 w_accept;
    logic                 w_cnt_load;
    logic [CNT_W-1:0]     w_cnt_val;
    logic                 w_cnt_dec;
    logic                 w_cnt_zero;
    logic                 w_se_nxt;
    logic                 w_busy_nxt;

    logic [CHAIN_LEN-1:0] r_pat;
    logic [CHAIN_LEN-1:0] r_exp;
    logic [CHAIN_LEN-1:0] r_mask;
    logic [CHAIN_LEN-1:0] r_resp;
    logic                 r_se;
    logic                 r_scan_in;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;

    logic [CHAIN_LEN-1:0] w_resp_shift;
    logic                 w_match;

    scan_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_cnt_load),
        .load_val (w_cnt_val),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    // Unload samples scan_out on every UNLOAD edge. The compare uses the
    // post-shift value so pass is ready in the same cycle as done.
    assign w_resp_shift = {r_resp[CHAIN_LEN-2:0], bus.scan_out};
    assign w_match      = &(~((w_resp_shift ^ r_exp) & r_mask));

    // ------------------------------------------------------------------
    // Next-state and phase counter control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        w_cnt_dec   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOAD;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = c_len_m1;
                end
            end
            ST_LOAD: begin
                if (w_cnt_zero) begin
                    w_cnt_load = 1'b1;
                    if (c_has_capture) begin
                        w_state_nxt = ST_CAPTURE;
                        w_cnt_val   = c_cap_m1;
                    end else begin
                        w_state_nxt = ST_UNLOAD;
                        w_cnt_val   = c_len_m1;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_UNLOAD;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = c_len_m1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_UNLOAD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered from the state being entered, so the chain
        // sees stable SE/scan_in for the whole state cycle.
        w_se_nxt   = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_UNLOAD);
        w_busy_nxt = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_CAPTURE) ||
                     (w_state_nxt == ST_UNLOAD);
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_se      <= 1'b0;
            r_scan_in <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_resp    <= '0;
            r_pat     <= '0;
            r_exp     <= '0;
            r_mask    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_se      <= w_se_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= (w_state_nxt == ST_DONE);
            r_scan_in <= 1'b0;

            if (w_accept) begin
                // MSB goes out in the first load cycle; the remainder is
                // kept left-aligned so the next bit is always r_pat MSB.
                r_scan_in <= bus.pattern[CHAIN_LEN-1];
                r_pat     <= {bus.pattern[CHAIN_LEN-2:0], 1'b0};
                r_exp     <= bus.expect_val;
                r_mask    <= bus.expect_mask;
                r_pass    <= 1'b0;
                r_resp    <= '0;
            end else if ((r_state == ST_LOAD) && (w_state_nxt == ST_LOAD)) begin
                r_scan_in <= r_pat[CHAIN_LEN-1];
                r_pat     <= {r_pat[CHAIN_LEN-2:0], 1'b0};
            end

            if (r_state == ST_UNLOAD) begin
                r_resp <= w_resp_shift;
                if (w_state_nxt == ST_DONE) begin
                    r_pass <= w_match;
                end
            end
        end
    end

    assign bus.SE       = r_se;
    assign bus.scan_in  = r_scan_in;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pass     = r_pass;
    assign bus.response = r_resp;

endmodule : scan_chain_driver
`default_nettype wire

// File: tb/tb_scan_chain_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_chain_driver
// Description : Self-checking bench for scan_chain_driver driving a 4-bit
//               scan counter (flop k = count[k]). Two driver instances:
//               CAPTURE_CYCLES=1 and CAPTURE_CYCLES=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_chain_driver;
    import scan_drv_pkg::*;

    localparam int c_len = 4;

    typedef struct {
        logic [3:0] pat;
        logic [3:0] ev;
        logic [3:0] msk;
        bit         cap0;
        logic [3:0] resp;
        logic       pass;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       sel0 = 1'b0;
    logic [3:0] pattern = '0;
    logic [3:0] expect_val = '0;
    logic [3:0] expect_mask = '0;
    logic [3:0] cnt1;
    logic [3:0] cnt0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    scan_chain_driver_if #(.CHAIN_LEN(c_len)) if1 ();
    scan_chain_driver_if #(.CHAIN_LEN(c_len)) if0 ();

    assign if1.start       = start & ~sel0;
    assign if0.start       = start & sel0;
    assign if1.pattern     = pattern;
    assign if0.pattern     = pattern;
    assign if1.expect_val  = expect_val;
    assign if0.expect_val  = expect_val;
    assign if1.expect_mask = expect_mask;
    assign if0.expect_mask = expect_mask;

    scan_chain_driver #(.CHAIN_LEN(c_len), .CAPTURE_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    scan_chain_driver #(.CHAIN_LEN(c_len), .CAPTURE_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    // 4-bit scan counter models: shift toward MSB when SE, else count up.
    always @(posedge clk) begin
        if (reset) cnt1 <= '0;
        else if (if1.SE) cnt1 <= {cnt1[2:0], if1.scan_in};
        else cnt1 <= cnt1 + 4'd1;
    end
    always @(posedge clk) begin
        if (reset) cnt0 <= '0;
        else if (if0.SE) cnt0 <= {cnt0[2:0], if0.scan_in};
        else cnt0 <= cnt0 + 4'd1;
    end
    assign if1.scan_out = cnt1[3];
    assign if0.scan_out = cnt0[3];

    // Observation mux for the instance selected by sel0.
    wire       o_se   = sel0 ? if0.SE   : if1.SE;
    wire       o_busy = sel0 ? if0.busy : if1.busy;
    wire       o_done = sel0 ? if0.done : if1.done;
    wire       o_pass = sel0 ? if0.pass : if1.pass;
    wire [3:0] o_resp = sel0 ? if0.response : if1.response;
    wire [3:0] o_cnt  = sel0 ? cnt0 : cnt1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full run; n counts negedges after the edge that samples start.
    task automatic run_vec(input vec_t v, input int idx);
        int done_at;
        int se_run;
        int se_max;
        int n_done;
        sel0 = v.cap0;
        @(negedge clk);
        pattern     = v.pat;
        expect_val  = v.ev;
        expect_mask = v.msk;
        start       = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        done_at = 0;
        se_run  = 0;
        se_max  = 0;
        n_done  = 0;
        for (int n = 1; n <= 14; n++) begin
            if (n > 1) @(negedge clk);
            if (o_se) se_run++;
            else se_run = 0;
            if (se_run > se_max) se_max = se_run;
            if (n == c_len + 1)
                check($sformatf("v%0d chain_loaded", idx), o_cnt, v.pat);
            if (o_done) begin
                n_done++;
                if (done_at == 0) begin
                    done_at = n;
                    check($sformatf("v%0d response", idx), o_resp, v.resp);
                    check($sformatf("v%0d pass", idx), o_pass, v.pass);
                end
            end
        end
        check($sformatf("v%0d done_latency", idx), done_at,
              2 * c_len + (v.cap0 ? 0 : 1) + 1);
        check($sformatf("v%0d se_run", idx), se_max, v.cap0 ? 2 * c_len : c_len);
        check($sformatf("v%0d done_count", idx), n_done, 1);
        check($sformatf("v%0d pass_held", idx), o_pass, v.pass);
        check($sformatf("v%0d resp_held", idx), o_resp, v.resp);
    endtask

    vec_t vecs[8];

    initial begin
        int first_done;
        int second_done;
        int n_done;

        vecs[0] = '{4'b0101, 4'b0110, 4'hF,    1'b0, 4'b0110, 1'b1};
        vecs[1] = '{4'b0101, 4'b0111, 4'hF,    1'b0, 4'b0110, 1'b0};
        vecs[2] = '{4'b0101, 4'b0111, 4'b1110, 1'b0, 4'b0110, 1'b1};
        vecs[3] = '{4'b1111, 4'b0000, 4'hF,    1'b0, 4'b0000, 1'b1};
        vecs[4] = '{4'b0011, 4'b1111, 4'h0,    1'b0, 4'b0100, 1'b1};
        vecs[5] = '{4'b1000, 4'b1001, 4'hF,    1'b0, 4'b1001, 1'b1};
        vecs[6] = '{4'b1101, 4'b1101, 4'hF,    1'b1, 4'b1101, 1'b1};
        vecs[7] = '{4'b0010, 4'b0000, 4'hF,    1'b1, 4'b0010, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst SE",       if1.SE,       1'b0);
        check("rst scan_in",  if1.scan_in,  1'b0);
        check("rst busy",     if1.busy,     1'b0);
        check("rst done",     if1.done,     1'b0);
        check("rst pass",     if1.pass,     1'b0);
        check("rst response", if1.response, 4'h0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset during UNLOAD (CAPTURE_CYCLES=1: UNLOAD occupies n=6..9)
        sel0 = 1'b0;
        @(negedge clk);
        pattern = 4'b0101; expect_val = 4'b0110; expect_mask = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort SE",       o_se,   1'b0);
        check("abort busy",     o_busy, 1'b0);
        check("abort response", o_resp, 4'h0);
        n_done = 0;
        for (int n = 0; n < 12; n++) begin
            if (o_done) n_done++;
            @(negedge clk);
        end
        check("abort no_done", n_done, 0);
        run_vec(vecs[0], 10);

        // start during LOAD and in DONE ignored; start in next IDLE accepted
        sel0 = 1'b0;
        @(negedge clk);
        pattern = 4'b0101; expect_val = 4'b0110; expect_mask = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        first_done  = 0;
        second_done = 0;
        n_done      = 0;
        for (int n = 1; n <= 26; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 2) start = 1'b1;
            if (n == 3) start = 1'b0;
            if (first_done != 0 && n == first_done + 1)
                check("restart idle_after_done", o_busy, 1'b0);
            if (first_done != 0 && n == first_done + 2) begin
                start = 1'b0;
                check("restart accepted", o_busy, 1'b1);
            end
            if (o_done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = n;
                    start = 1'b1;
                end else if (second_done == 0) begin
                    second_done = n;
                end
            end
        end
        start = 1'b0;
        check("restart first_done", first_done, 10);
        check("restart second_done", second_done, 21);
        check("restart done_count", n_done, 2);
        check("restart pass", o_pass, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_scan_chain_driver
`default_nettype wire
